uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
- UART receive deserializer inside Uart. Runs on UARTCLK.
- Samples the serial input UARTRXD using a 16x baud tick from the baud-rate generator, and assembles 5–8 bit characters with optional parity.
- Pushes each character, with its FE/PE/BE status bits, into the RX FIFO (the downstream stage), which APB reads through UARTDR.

Parameters:
- SYNC_STAGES, 2, number of flops in the UARTRXD synchronizer (minimum 2).
- OVERSAMPLE, 16, baud ticks per bit. The mid-bit sample point is OVERSAMPLE/2.

Ports:
- UARTCLK  input  1  UART reference clock.
- nUARTRST  input  1  reset, synchronous, active-low.
- baud16_tick  input  1  one-cycle enable pulse at 16x the baud rate.
- rx_en  input  1  receiver enable (UARTEN & RXE).
- UARTRXD  input  1  asynchronous serial input; idle level is 1.
- wlen  input  2  character length: 00=5, 01=6, 10=7, 11=8 bits.
- pen  input  1  parity enable.
- eps  input  1  even parity select.
- sps  input  1  stick parity select.
- rx_word  output  11  {BE, PE, FE, data[7:0]}; valid only when rx_push=1.
- rx_push  output  1  one-cycle write strobe to the RX FIFO.
- rx_busy  output  1  high while a frame is in progress (states START through STOP).

Behaviour:
- Reset (nUARTRST=0 at a UARTCLK edge):
  - state=IDLE; synchronizer flops=1; all counters=0.
  - Outputs: rx_word=0, rx_push=0, rx_busy=0.
- Synchronization: all sampling uses rxd_s, the output of the SYNC_STAGES synchronizer. Counters and sampling advance only on cycles where baud16_tick=1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on a tick with rx_en=1 and rxd_s=0, go to START with tick_cnt=0.
- START: sample on the tick where tick_cnt==7.
  - rxd_s=1: false start; go to IDLE, no push.
  - rxd_s=0: go to DATA with tick_cnt=0 and bit_cnt=0.
- DATA: sample on the tick where tick_cnt==15.
  - Store the bit LSB-first into data[bit_cnt].
  - After bit (5+wlen)-1, go to PARITY if pen=1, otherwise to STOP.
  - Data bits at index ≥ the word length read as 0.
- PARITY: sample p on the tick where tick_cnt==15.
  - Expected parity when sps=1: ~eps.
  - Expected parity when sps=0 and eps=1: XOR of the received data bits.
  - Expected parity when sps=0 and eps=0: inverted XOR of the received data bits.
  - PE = (p != expected).
- STOP: sample on the tick where tick_cnt==15.
  - FE = ~rxd_s.
  - Break: data==0, stop==0, and (pen=0 or p==0). On break, BE=1, FE=0, PE=0, data=0.
- Push: rx_push=1 for exactly one UARTCLK cycle, the cycle after the stop-sample tick. rx_word is held until the next push.
- Next state after STOP:
  - stop==1: IDLE.
  - stop==0 (FE or BE): WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rxd_s=1, then go to IDLE. No new start bit is recognized while the line stays low.
- Only one stop bit is checked. STP2 is ignored; the second stop bit looks like idle.
- rx_en deasserted in any non-IDLE state: go to IDLE on the next cycle, no push, partial data discarded.
- FIFO full: the push is still issued. Overrun (OE) is the FIFO's responsibility.
- Synchronous reset mid-frame: the frame is aborted, no push, and the reset values above apply on the next edge.
- Counters: tick_cnt is 4-bit and wraps to 0 after each sample; bit_cnt is 3-bit.
- Latency: falling edge on UARTRXD to rx_push is SYNC_STAGES + frame_ticks + 1 cycles, measured with baud16_tick tied high.

Decomposition:
- uart_pkg:
  - rx_state_t enum.
  - WLEN_5..WLEN_8 constants.
  - rx_word field offsets: BE=10, PE=9, FE=8.
  - OVERSAMPLE/MID_SAMPLE constants.
- Sub-module uart_sync_bit: an N-flop synchronizer with reset value 1. It is reused for the nUARTCTS/DSR/DCD/RI inputs.

Test Plan:
- baud16_tick=1, 8N1, send 0x55 → one rx_push with rx_word=0x055, exactly 16*10−8+1 cycles after the sync output falls.
- 7-bit, pen=1, eps=1, sps=0, send 0x41 (p=0) → rx_word=0x041. Repeat with p forced to 1 → rx_word=0x241.
- 8N1, 0xA5 with stop bit=0, then line high → rx_word=0x1A5, FSM passes through WAIT_HIGH, and the next byte 0x3C gives rx_word=0x03C.
- 8E1, line held low for 20 bit times → exactly one push with rx_word=0x400, then no further push until the line returns high.
- Line low for 4 ticks then high (glitch) → no rx_push, rx_busy falls back to 0, and a following 0x12 is received correctly.
- nUARTRST=0 or rx_en=0 asserted at data bit 3 → no push. The next full frame 0xFF gives rx_word=0x0FF; stick parity sps=1, eps=1, p=0 gives PE=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, word-length
// codes, receive-word field positions and oversampling defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  // Status bit positions inside the 11-bit receive word.
  localparam int RX_BE_BIT = 10;
  localparam int RX_PE_BIT = 9;
  localparam int RX_FE_BIT = 8;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_SAMPLE = UART_OVERSAMPLE / 2;

  // Index of the last data bit for a given word-length code.
  function automatic logic [2:0] last_data_idx(input logic [1:0] wlen);
    case (wlen)
      WLEN_5:  return 3'd4;
      WLEN_6:  return 3'd5;
      WLEN_7:  return 3'd6;
      WLEN_8:  return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// N-flop synchronizer for an asynchronous level input. Resets to 1 so an
// idle-high line (or inactive-high modem input) does not glitch out of reset.
module uart_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through the flop chain; oldest sample is the output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversamples the synchronized serial line,
// assembles 5-8 bit characters with optional parity and pushes
// {BE, PE, FE, data} to the RX FIFO once per frame.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE
) (
  input  logic        UARTCLK,
  input  logic        nUARTRST,
  input  logic        baud16_tick,
  input  logic        rx_en,
  input  logic        UARTRXD,
  input  logic [1:0]  wlen,
  input  logic        pen,
  input  logic        eps,
  input  logic        sps,
  output logic [10:0] rx_word,
  output logic        rx_push,
  output logic        rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic             rxd_s;
  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] tick_cnt, tick_nx;
  logic [2:0]       bit_cnt, bit_nx;
  logic [7:0]       data, data_nx;
  logic             par_bit, par_nx;
  logic             pe, pe_nx;
  logic [10:0]      word_nx;
  logic             push_nx;
  logic             exp_par;
  logic             brk;

  uart_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (UARTCLK),
    .rst_n (nUARTRST),
    .d     (UARTRXD),
    .q     (rxd_s)
  );

  // Unreceived high data bits are zero, so XOR over all eight is the data parity.
  assign exp_par = sps ? ~eps : (eps ? ^data : ~(^data));
  // A break is an all-zero character with zero parity (if any) and zero stop.
  assign brk     = (data == 8'h00) && !rxd_s && (!pen || !par_bit);
  assign rx_busy = (state == RX_START) || (state == RX_DATA) ||
                   (state == RX_PARITY) || (state == RX_STOP);

  // Frame state register plus the datapath it carries.
  always_ff @(posedge UARTCLK) begin
    if (!nUARTRST) begin
      state    <= RX_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      data     <= '0;
      par_bit  <= 1'b0;
      pe       <= 1'b0;
      rx_word  <= '0;
      rx_push  <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      data     <= data_nx;
      par_bit  <= par_nx;
      pe       <= pe_nx;
      rx_word  <= word_nx;
      rx_push  <= push_nx;
    end
  end

  // Next-state, sampling and push decisions; all progress is gated by the tick.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    data_nx  = data;
    par_nx   = par_bit;
    pe_nx    = pe;
    word_nx  = rx_word;
    push_nx  = 1'b0;

    if (state != RX_IDLE && !rx_en) begin
      state_nx = RX_IDLE;
      tick_nx  = '0;
      bit_nx   = '0;
    end else if (baud16_tick) begin
      case (state)
        RX_IDLE: begin
          tick_nx = '0;
          if (rx_en && !rxd_s) state_nx = RX_START;
        end
        RX_START: begin
          if (tick_cnt == MID_LAST) begin
            tick_nx = '0;
            if (rxd_s) begin
              state_nx = RX_IDLE;
            end else begin
              state_nx = RX_DATA;
              bit_nx   = '0;
              data_nx  = '0;
              par_nx   = 1'b0;
              pe_nx    = 1'b0;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick_cnt == BIT_LAST) begin
            tick_nx          = '0;
            data_nx[bit_cnt] = rxd_s;
            if (bit_cnt == last_data_idx(wlen)) begin
              bit_nx   = '0;
              state_nx = pen ? RX_PARITY : RX_STOP;
            end else begin
              bit_nx = bit_cnt + 3'd1;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (tick_cnt == BIT_LAST) begin
            tick_nx  = '0;
            par_nx   = rxd_s;
            pe_nx    = (rxd_s != exp_par);
            state_nx = RX_STOP;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_cnt == BIT_LAST) begin
            tick_nx = '0;
            push_nx = 1'b1;
            word_nx = '0;
            if (brk) begin
              word_nx[RX_BE_BIT] = 1'b1;
            end else begin
              word_nx[7:0]       = data;
              word_nx[RX_PE_BIT] = pe;
              word_nx[RX_FE_BIT] = ~rxd_s;
            end
            state_nx = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_s) state_nx = RX_IDLE;
        end
        default: state_nx = RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed frames with hand-computed
// receive words queued at stimulus time and popped by a push monitor.
module tb_uart_rx_deser;

  localparam int SYNC_STAGES = 2;
  localparam int OVERSAMPLE  = 16;
  localparam int LATENCY     = SYNC_STAGES + OVERSAMPLE * 10 - OVERSAMPLE / 2 + 1;

  logic        UARTCLK  = 1'b0;
  logic        nUARTRST = 1'b0;
  logic        baud16_tick = 1'b1;
  logic        rx_en    = 1'b0;
  logic        UARTRXD  = 1'b1;
  logic [1:0]  wlen     = 2'b11;
  logic        pen      = 1'b0;
  logic        eps      = 1'b0;
  logic        sps      = 1'b0;
  logic [10:0] rx_word;
  logic        rx_push;
  logic        rx_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_div = 1;
  int tick_ph  = 0;

  typedef struct {
    logic [10:0] word;
    bit          chk_lat;
    int          t0;
  } exp_t;

  exp_t sb[$];

  uart_rx_deser #(.SYNC_STAGES(SYNC_STAGES), .OVERSAMPLE(OVERSAMPLE)) dut (
    .UARTCLK     (UARTCLK),
    .nUARTRST    (nUARTRST),
    .baud16_tick (baud16_tick),
    .rx_en       (rx_en),
    .UARTRXD     (UARTRXD),
    .wlen        (wlen),
    .pen         (pen),
    .eps         (eps),
    .sps         (sps),
    .rx_word     (rx_word),
    .rx_push     (rx_push),
    .rx_busy     (rx_busy)
  );

  always #5 UARTCLK = ~UARTCLK;

  always @(posedge UARTCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Baud tick: constant high, or one pulse every tick_div cycles.
  initial begin
    forever begin
      @(negedge UARTCLK);
      if (tick_div <= 1) begin
        baud16_tick = 1'b1;
      end else begin
        tick_ph     = (tick_ph + 1) % tick_div;
        baud16_tick = (tick_ph == 0);
      end
    end
  end

  // Push monitor: every push must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge UARTCLK);
      if (rx_push === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_push actual=0x%0h required=none", rx_word);
        end else begin
          e = sb.pop_front();
          check("rx_word", 32'(rx_word), 32'(e.word));
          if (e.chk_lat) check("latency", 32'(cyc - e.t0), 32'(LATENCY));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge UARTCLK);
  endtask

  task automatic line_bit(input logic b);
    UARTRXD = b;
    repeat (OVERSAMPLE * tick_div) @(negedge UARTCLK);
  endtask

  // Sends one frame. abort_kind: 0 none, 1 reset, 2 rx_en drop, mid data bit abort_at.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                            input logic par, input logic stop, input logic [10:0] exp,
                            input bit chk_lat, input int abort_kind, input int abort_at);
    exp_t e;
    if (abort_kind == 0) begin
      e.word = exp; e.chk_lat = chk_lat; e.t0 = cyc;
      sb.push_back(e);
    end
    line_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (abort_kind != 0 && i == abort_at) begin
        UARTRXD = d[i];
        idle(OVERSAMPLE * tick_div / 2);
        if (abort_kind == 1) begin
          nUARTRST = 1'b0;
          UARTRXD  = 1'b1;
          idle(1);
          check("abort_rst_word", 32'(rx_word), 32'h0);
          check("abort_rst_push", 32'(rx_push), 32'h0);
          check("abort_rst_busy", 32'(rx_busy), 32'h0);
          nUARTRST = 1'b1;
        end else begin
          rx_en   = 1'b0;
          UARTRXD = 1'b1;
          idle(4);
          check("abort_en_busy", 32'(rx_busy), 32'h0);
          rx_en = 1'b1;
        end
        return;
      end
      line_bit(d[i]);
    end
    if (has_par) line_bit(par);
    line_bit(stop);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 3000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge UARTCLK);
      budget--;
    end
    check({"drain_", name}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge UARTCLK);
    check("reset_word", 32'(rx_word), 32'h0);
    check("reset_push", 32'(rx_push), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    nUARTRST = 1'b1;
    rx_en    = 1'b1;
    idle(20);

    // 8N1 0x55 with latency measurement.
    wlen = 2'b11; pen = 1'b0;
    send_frame(8'h55, 8, 0, 1'b0, 1'b1, 11'h055, 1, 0, 0);
    idle(32);
    drain("8n1");

    // 7-bit even parity: matching then wrong parity; 6-bit odd; 5-bit no parity.
    wlen = 2'b10; pen = 1'b1; eps = 1'b1; sps = 1'b0;
    send_frame(8'h41, 7, 1, 1'b0, 1'b1, 11'h041, 0, 0, 0);
    idle(32);
    send_frame(8'h41, 7, 1, 1'b1, 1'b1, 11'h241, 0, 0, 0);
    idle(32);
    wlen = 2'b01; eps = 1'b0;
    send_frame(8'h2A, 6, 1, 1'b0, 1'b1, 11'h02A, 0, 0, 0);
    idle(32);
    wlen = 2'b00; pen = 1'b0;
    send_frame(8'hFF, 5, 0, 1'b0, 1'b1, 11'h01F, 0, 0, 0);
    idle(32);
    drain("parity");

    // Framing error, line held low, then recovery.
    wlen = 2'b11; pen = 1'b0;
    send_frame(8'hA5, 8, 0, 1'b0, 1'b0, 11'h1A5, 0, 0, 0);
    idle(3 * OVERSAMPLE);
    check("wait_high_busy", 32'(rx_busy), 32'h0);
    UARTRXD = 1'b1;
    idle(32);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b1, 11'h03C, 0, 0, 0);
    idle(32);
    drain("fe");

    // Break on 8E1: line low for 20 bit times gives exactly one push.
    pen = 1'b1; eps = 1'b1;
    e.word = 11'h400; e.chk_lat = 0; e.t0 = cyc;
    sb.push_back(e);
    UARTRXD = 1'b0;
    idle(5 * OVERSAMPLE);
    check("break_mid_busy", 32'(rx_busy), 32'h1);
    idle(15 * OVERSAMPLE);
    check("break_end_busy", 32'(rx_busy), 32'h0);
    UARTRXD = 1'b1;
    idle(32);
    drain("break");

    // Glitch shorter than half a bit is rejected.
    pen = 1'b0;
    UARTRXD = 1'b0;
    idle(4);
    UARTRXD = 1'b1;
    idle(20);
    check("glitch_busy", 32'(rx_busy), 32'h0);
    send_frame(8'h12, 8, 0, 1'b0, 1'b1, 11'h012, 0, 0, 0);
    idle(32);
    drain("glitch");

    // Sparse baud tick: one pulse every third cycle.
    tick_div = 3;
    idle(3);
    send_frame(8'h96, 8, 0, 1'b0, 1'b1, 11'h096, 0, 0, 0);
    idle(96);
    tick_div = 1;
    idle(3);
    drain("tickdiv");

    // Aborts at data bit 3, then stick-parity frames.
    send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 11'h000, 0, 1, 3);
    idle(4 * OVERSAMPLE);
    send_frame(8'hF0, 8, 0, 1'b0, 1'b1, 11'h000, 0, 2, 3);
    idle(4 * OVERSAMPLE);
    pen = 1'b1; sps = 1'b1; eps = 1'b1;
    send_frame(8'hFF, 8, 1, 1'b0, 1'b1, 11'h0FF, 0, 0, 0);
    idle(32);
    eps = 1'b0;
    send_frame(8'h81, 8, 1, 1'b0, 1'b1, 11'h281, 0, 0, 0);
    idle(32);
    drain("stick");

    idle(100);
    check("final_queue", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
